// File: rtl/ex_muldiv_unit.sv
// Iterative unsigned multiply/divide for the EX stage: one radix-2 step per cycle,
// stalls the front of the pipeline until the result is handed to EX/MEM.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int AW = 2 * XLEN + 1;
  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Multiply step: acc = {carry, product_hi, multiplier/product_lo}.
  function automatic logic [AW-1:0] mul_step(input logic [AW-1:0] acc,
                                             input logic [XLEN-1:0] mcand);
    logic [XLEN:0] upper;
    upper = acc[AW-1:XLEN];
    if (acc[0]) upper = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mcand};
    return {1'b0, upper, acc[XLEN-1:1]};
  endfunction

  // Restoring divide step: acc = {rem (XLEN+1 bits), quot}; trial bit XLEN is the borrow.
  function automatic logic [AW-1:0] div_step(input logic [AW-1:0] acc,
                                             input logic [XLEN-1:0] dvsr);
    logic [AW-1:0] sh;
    logic [XLEN:0] trial;
    sh    = {acc[AW-2:0], 1'b0};
    trial = sh[AW-1:XLEN] - {1'b0, dvsr};
    if (!trial[XLEN]) sh = {trial, sh[XLEN-1:1], 1'b1};
    return sh;
  endfunction

  // Low half is the MUL product or DIVU quotient, high half the MULHU product or REMU remainder.
  function automatic logic [XLEN-1:0] pick_result(input logic [1:0] sel,
                                                  input logic [AW-1:0] acc);
    return sel[0] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic [AW-1:0]   acc_nxt;

  assign accept  = start & (state_q != S_RUN) & ~flush;
  assign acc_nxt = op_q[1] ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;

    case (state_q)
      S_RUN: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = pick_result(op_q, acc_nxt);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          op_d  = op;
          cnt_d = '0;
          // Multiplicand is A with B as multiplier; for division B is the divisor.
          opb_d = op[1] ? b : a;
          acc_d = {{(XLEN + 1){1'b0}}, (op[1] ? a : b)};
          if (op[1] && (b == '0)) begin
            state_d  = S_DONE;
            result_d = op[0] ? a : {XLEN{1'b1}};
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase

    // Squash wins over both a fresh accept and a completing step.
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = accept | busy_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed timing scenarios plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall;

  int tests_run    = 0;
  int tests_failed = 0;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [XLEN-1:0] ref_model(input logic [1:0] o,
                                                input logic [XLEN-1:0] x,
                                                input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    p = (2*XLEN)'(x) * (2*XLEN)'(y);
    case (o)
      2'd0:    r = p[XLEN-1:0];
      2'd1:    r = p[2*XLEN-1:XLEN];
      2'd2:    r = (y == 0) ? {XLEN{1'b1}} : x / y;
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // Issues one op (cycle 0 = now), follows it to completion and reports the cycle
  // in which done was seen, the result, and how many cycles had wrong busy/stall/done.
  // Returns at the negedge of the done cycle with start already dropped.
  task automatic do_op(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                       input bit keep_start, output int done_cyc,
                       output logic [XLEN-1:0] res, output int tim_err);
    int  exp_done;
    bit  exp_busy;
    bit  exp_stall;
    start = 1'b1; op = o; a = x; b = y;
    exp_done = (o[1] && y == 0) ? 1 : XLEN + 1;
    tim_err  = 0;
    done_cyc = -1;
    res      = 'x;
    #1;
    if (stall !== 1'b1 || busy !== 1'b0) tim_err++;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    for (int k = 1; k <= XLEN + 3 && done_cyc < 0; k++) begin
      @(negedge clk);
      exp_busy  = (k < exp_done);
      exp_stall = exp_busy ? 1'b1 : keep_start;
      if (busy !== exp_busy || stall !== exp_stall) tim_err++;
      if (done === 1'b1 && busy === 1'b1) tim_err++;
      if (done === 1'b1) begin
        done_cyc = k;
        res      = result;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, stall} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/done/stall=%b required 000", {busy, done, stall});
    end
    tests_run++;
    if (result !== '0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h required 0", result);
    end
    start = 1'b1;
    #1;
    tests_run++;
    if (stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_stall_comb: got %b required 1", stall);
    end
    start = 1'b0;
    #1;
  endtask

  task automatic test_mul_basic();
    int dc, te;
    logic [XLEN-1:0] r;
    @(posedge clk); #1;
    do_op(2'd0, 32'd7, 32'd6, 1'b0, dc, r, te);
    tests_run++;
    if (dc !== XLEN + 1 || te !== 0) begin
      tests_failed++;
      $display("FAIL mul_timing: done cycle %0d timing errors %0d required %0d and 0", dc, te, XLEN + 1);
    end
    tests_run++;
    if (r !== 32'h0000002A) begin
      tests_failed++;
      $display("FAIL mul_7x6: got %h required 0000002a", r);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || result !== 32'h0000002A) begin
      tests_failed++;
      $display("FAIL mul_hold: done=%b result=%h required 0 and 0000002a", done, result);
    end
  endtask

  task automatic test_back_to_back();
    int dc, te;
    logic [XLEN-1:0] r;
    @(posedge clk); #1;
    do_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, dc, r, te);
    tests_run++;
    if (r !== 32'h00000001 || dc !== XLEN + 1 || te !== 0) begin
      tests_failed++;
      $display("FAIL b2b_mul: got %h cyc %0d terr %0d required 00000001 cyc %0d", r, dc, te, XLEN + 1);
    end
    do_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, dc, r, te);
    tests_run++;
    if (r !== 32'hFFFFFFFE || dc !== XLEN + 1 || te !== 0) begin
      tests_failed++;
      $display("FAIL b2b_mulhu: got %h cyc %0d terr %0d required fffffffe cyc %0d", r, dc, te, XLEN + 1);
    end
  endtask

  task automatic test_div();
    int dc, te;
    logic [XLEN-1:0] r;
    logic [1:0]      ops [4]  = '{2'd2, 2'd3, 2'd2, 2'd3};
    logic [XLEN-1:0] bs  [4]  = '{32'd7, 32'd7, 32'd0, 32'd0};
    logic [XLEN-1:0] xs  [4]  = '{32'd100, 32'd100, 32'd5, 32'd5};
    logic [XLEN-1:0] exp [4]  = '{32'h0000000E, 32'h00000002, 32'hFFFFFFFF, 32'h00000005};
    int              cyc [4]  = '{XLEN + 1, XLEN + 1, 1, 1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      do_op(ops[i], xs[i], bs[i], 1'b0, dc, r, te);
      tests_run++;
      if (r !== exp[i] || dc !== cyc[i] || te !== 0) begin
        tests_failed++;
        $display("FAIL div_case%0d: got %h cyc %0d terr %0d required %h cyc %0d",
                 i, r, dc, te, exp[i], cyc[i]);
      end
    end
  endtask

  task automatic test_random();
    int dc, te, sel;
    logic [1:0]      o;
    logic [XLEN-1:0] x, y, r, e;
    for (int i = 0; i < 24; i++) begin
      o   = 2'($urandom_range(0, 3));
      x   = $urandom;
      sel = $urandom_range(0, 3);
      y   = (sel == 0) ? '0 : (sel == 1) ? XLEN'($urandom_range(1, 15)) : XLEN'($urandom);
      e   = ref_model(o, x, y);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op(o, x, y, bit'($urandom_range(0, 1)), dc, r, te);
      tests_run++;
      if (r !== e || te !== 0 || dc !== ((o[1] && y == 0) ? 1 : XLEN + 1)) begin
        tests_failed++;
        $display("FAIL random%0d op%0d a=%h b=%h: got %h cyc %0d terr %0d required %h",
                 i, o, x, y, r, dc, te, e);
      end
    end
  endtask

  task automatic test_flush();
    int bad;
    logic [XLEN-1:0] prior;
    @(negedge clk);
    prior = result;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bad = 0;
    for (int k = 11; k <= 40; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || result !== prior) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL flush_mid_run: %0d bad cycles required 0 (result %h prior %h)", bad, result, prior);
    end
  endtask

  task automatic test_rst_mid_run();
    int dc, te;
    logic [XLEN-1:0] r;
    @(posedge clk); #1;
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, done, stall} !== 3'b000 || result !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_run: busy/done/stall=%b result=%h required 000 and 0",
               {busy, done, stall}, result);
    end
    do_op(2'd0, 32'd2, 32'd5, 1'b0, dc, r, te);
    tests_run++;
    if (r !== 32'd10 || dc !== XLEN + 1 || te !== 0) begin
      tests_failed++;
      $display("FAIL after_rst_mul: got %h cyc %0d terr %0d required 0000000a cyc %0d", r, dc, te, XLEN + 1);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_back_to_back();
    test_div();
    test_flush();
    test_rst_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
